// File: rtl/exmem_pipe_reg.sv
// EX/MEM stage register for the WISC pipeline: valid/ready handshake, flush,
// optional two-entry skid buffer and a saturating stall-cycle counter.
module exmem_pipe_reg #(
    parameter int DATA_W      = 16,
    parameter int RD_W        = 4,
    parameter bit SKID_EN     = 1'b1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   mem_to_reg_in,
    input  logic                   reg_to_mem_in,
    input  logic [RD_W-1:0]        reg_rd_in,
    input  logic [DATA_W-1:0]      alu_result_in,
    input  logic [DATA_W-1:0]      save_word_data_in,
    input  logic                   ret_future_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   mem_to_reg_out,
    output logic                   reg_to_mem_out,
    output logic [RD_W-1:0]        reg_rd_out,
    output logic [DATA_W-1:0]      alu_result_out,
    output logic [DATA_W-1:0]      save_word_data_out,
    output logic                   ret_future_out,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef struct packed {
        logic              mem_to_reg;
        logic              reg_to_mem;
        logic [RD_W-1:0]   reg_rd;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] save_word_data;
        logic              ret_future;
    } entry_t;

    entry_t m_q, s_q, in_e;
    logic   m_vld, s_vld;
    logic   push, pop;

    assign in_e = '{mem_to_reg:     mem_to_reg_in,
                    reg_to_mem:     reg_to_mem_in,
                    reg_rd:         reg_rd_in,
                    alu_result:     alu_result_in,
                    save_word_data: save_word_data_in,
                    ret_future:     ret_future_in};

    // With the skid entry, in_ready is a pure flop output so MEM stalls never
    // reach back into EX combinationally.
    assign in_ready = SKID_EN ? !s_vld : (!m_vld || out_ready);
    assign push     = in_valid && in_ready;
    assign pop      = m_vld && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld        <= 1'b0;
            s_vld        <= 1'b0;
            m_q          <= '0;
            s_q          <= '0;
            stall_cycles <= '0;
        end else begin
            if (m_vld && !out_ready && (stall_cycles != '1))
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);

            if (flush) begin
                m_vld <= 1'b0;
                s_vld <= 1'b0;
            end else if (!m_vld || pop) begin
                if (s_vld) begin
                    m_q   <= s_q;
                    m_vld <= 1'b1;
                    s_vld <= 1'b0;
                end else if (push) begin
                    m_q   <= in_e;
                    m_vld <= 1'b1;
                end else begin
                    m_vld <= 1'b0;
                end
            end else if (SKID_EN && push) begin
                s_q   <= in_e;
                s_vld <= 1'b1;
            end
        end
    end

    // Control bits are gated so a bubble never starts a memory access or return.
    assign out_valid          = m_vld;
    assign mem_to_reg_out     = m_q.mem_to_reg && m_vld;
    assign reg_to_mem_out     = m_q.reg_to_mem && m_vld;
    assign ret_future_out     = m_q.ret_future && m_vld;
    assign reg_rd_out         = m_q.reg_rd;
    assign alu_result_out     = m_q.alu_result;
    assign save_word_data_out = m_q.save_word_data;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Directed bench: skid-buffer instance (a) and single-entry instance (b, 2-bit counter).
module tb_exmem_pipe_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance a: SKID_EN=1, defaults
    logic        iv_a, ir_a, fl_a, m2r_a, r2m_a, ret_a, ov_a, or_a;
    logic [3:0]  rd_a;
    logic [15:0] alu_a, sw_a;
    logic        m2r_o_a, r2m_o_a, ret_o_a;
    logic [3:0]  rd_o_a;
    logic [15:0] alu_o_a, sw_o_a, st_a;

    // instance b: SKID_EN=0, STALL_CNT_W=2
    logic        iv_b, ir_b, fl_b, m2r_b, r2m_b, ret_b, ov_b, or_b;
    logic [3:0]  rd_b;
    logic [15:0] alu_b, sw_b;
    logic        m2r_o_b, r2m_o_b, ret_o_b;
    logic [3:0]  rd_o_b;
    logic [15:0] alu_o_b, sw_o_b;
    logic [1:0]  st_b;

    exmem_pipe_reg u_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .flush(fl_a),
        .mem_to_reg_in(m2r_a), .reg_to_mem_in(r2m_a), .reg_rd_in(rd_a),
        .alu_result_in(alu_a), .save_word_data_in(sw_a), .ret_future_in(ret_a),
        .out_valid(ov_a), .out_ready(or_a), .mem_to_reg_out(m2r_o_a),
        .reg_to_mem_out(r2m_o_a), .reg_rd_out(rd_o_a), .alu_result_out(alu_o_a),
        .save_word_data_out(sw_o_a), .ret_future_out(ret_o_a), .stall_cycles(st_a)
    );

    exmem_pipe_reg #(.SKID_EN(1'b0), .STALL_CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .flush(fl_b),
        .mem_to_reg_in(m2r_b), .reg_to_mem_in(r2m_b), .reg_rd_in(rd_b),
        .alu_result_in(alu_b), .save_word_data_in(sw_b), .ret_future_in(ret_b),
        .out_valid(ov_b), .out_ready(or_b), .mem_to_reg_out(m2r_o_b),
        .reg_to_mem_out(r2m_o_b), .reg_rd_out(rd_o_b), .alu_result_out(alu_o_b),
        .save_word_data_out(sw_o_b), .ret_future_out(ret_o_b), .stall_cycles(st_b)
    );

    // inputs take effect at the next edge; outputs are read 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iv_a = 0; fl_a = 0; m2r_a = 0; r2m_a = 0; ret_a = 0; rd_a = 0; alu_a = 0; sw_a = 0; or_a = 1;
        iv_b = 0; fl_b = 0; m2r_b = 0; r2m_b = 0; ret_b = 0; rd_b = 0; alu_b = 0; sw_b = 0; or_b = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_ov_a got %b exp 0", ov_a); end
        checks++; if ({m2r_o_a, r2m_o_a, ret_o_a, rd_o_a, alu_o_a, sw_o_a} !== 39'd0) begin errors++; $display("FAIL reset_fields_a got %h exp 0", {m2r_o_a, r2m_o_a, ret_o_a, rd_o_a, alu_o_a, sw_o_a}); end
        checks++; if (st_a !== 16'd0) begin errors++; $display("FAIL reset_stall_a got %0d exp 0", st_a); end
        checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL reset_ir_a got %b exp 1", ir_a); end
        checks++; if ({ov_b, alu_o_b, st_b} !== 19'd0) begin errors++; $display("FAIL reset_b got %h exp 0", {ov_b, alu_o_b, st_b}); end
        checks++; if (ir_b !== 1'b1) begin errors++; $display("FAIL reset_ir_b got %b exp 1", ir_b); end
    endtask

    task automatic test_streaming();
        or_a = 1;
        for (int i = 1; i <= 4; i++) begin
            iv_a = 1; alu_a = 16'(i);
            tick();
            checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL stream_ov[%0d] got %b exp 1", i, ov_a); end
            checks++; if (alu_o_a !== 16'(i)) begin errors++; $display("FAIL stream_alu[%0d] got %h exp %h", i, alu_o_a, 16'(i)); end
        end
        iv_a = 0;
        tick();
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", ov_a); end
        checks++; if (st_a !== 16'd0) begin errors++; $display("FAIL stream_stall got %0d exp 0", st_a); end
    endtask

    task automatic test_backpressure();
        or_a = 0;
        iv_a = 1; alu_a = 16'h1111; rd_a = 4'd3; m2r_a = 1;
        tick();
        checks++; if (alu_o_a !== 16'h1111) begin errors++; $display("FAIL bp_A_alu got %h exp 1111", alu_o_a); end
        checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL bp_ir_after_A got %b exp 1", ir_a); end
        alu_a = 16'h2222; rd_a = 4'd5; m2r_a = 0;
        tick();
        checks++; if (ir_a !== 1'b0) begin errors++; $display("FAIL bp_ir_after_B got %b exp 0", ir_a); end
        iv_a = 0;
        tick();
        tick();
        checks++; if (st_a !== 16'd3) begin errors++; $display("FAIL bp_stall got %0d exp 3", st_a); end
        checks++; if ({ov_a, m2r_o_a, rd_o_a, alu_o_a} !== {1'b1, 1'b1, 4'd3, 16'h1111}) begin errors++; $display("FAIL bp_hold_A got %h exp %h", {ov_a, m2r_o_a, rd_o_a, alu_o_a}, {1'b1, 1'b1, 4'd3, 16'h1111}); end
        or_a = 1;
        tick();
        checks++; if ({ov_a, m2r_o_a, rd_o_a, alu_o_a} !== {1'b1, 1'b0, 4'd5, 16'h2222}) begin errors++; $display("FAIL bp_B got %h exp %h", {ov_a, m2r_o_a, rd_o_a, alu_o_a}, {1'b1, 1'b0, 4'd5, 16'h2222}); end
        checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL bp_ir_return got %b exp 1", ir_a); end
        iv_a = 1; alu_a = 16'h3333; rd_a = 4'd7;
        tick();
        checks++; if ({ov_a, alu_o_a} !== {1'b1, 16'h3333}) begin errors++; $display("FAIL bp_C got %h exp 13333", {ov_a, alu_o_a}); end
        iv_a = 0;
        tick();
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", ov_a); end
        checks++; if (st_a !== 16'd3) begin errors++; $display("FAIL bp_stall_hold got %0d exp 3", st_a); end
    endtask

    task automatic test_flush();
        or_a = 0;
        iv_a = 1; alu_a = 16'hAAAA; m2r_a = 1; r2m_a = 1;
        tick();
        alu_a = 16'hBBBB;
        tick();
        alu_a = 16'hCCCC; fl_a = 1;
        tick();
        checks++; if ({ov_a, m2r_o_a, r2m_o_a} !== 3'b000) begin errors++; $display("FAIL flush_out got %b exp 000", {ov_a, m2r_o_a, r2m_o_a}); end
        checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL flush_ir got %b exp 1", ir_a); end
        fl_a = 0; iv_a = 0; m2r_a = 0; r2m_a = 0; or_a = 1;
        tick();
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL flush_no_C got %b exp 0", ov_a); end
    endtask

    task automatic test_bubble_gating();
        or_a = 1;
        iv_a = 1; r2m_a = 1; ret_a = 1; alu_a = 16'h0042;
        tick();
        checks++; if ({ov_a, r2m_o_a, ret_o_a} !== 3'b111) begin errors++; $display("FAIL gate_valid got %b exp 111", {ov_a, r2m_o_a, ret_o_a}); end
        iv_a = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({ov_a, r2m_o_a, ret_o_a} !== 3'b000) begin errors++; $display("FAIL gate_bubble[%0d] got %b exp 000", i, {ov_a, r2m_o_a, ret_o_a}); end
        end
        r2m_a = 0; ret_a = 0;
    endtask

    task automatic test_noskid_saturate();
        or_b = 0;
        iv_b = 1; alu_b = 16'h00AA;
        tick();
        #1;
        checks++; if (ir_b !== 1'b0) begin errors++; $display("FAIL ns_ir_full got %b exp 0", ir_b); end
        alu_b = 16'h00CC;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (st_b !== 2'd3) begin errors++; $display("FAIL ns_stall_sat got %0d exp 3", st_b); end
        checks++; if ({ov_b, alu_o_b} !== {1'b1, 16'h00AA}) begin errors++; $display("FAIL ns_hold got %h exp 100aa", {ov_b, alu_o_b}); end
        or_b = 1; alu_b = 16'h00BB;
        #1;
        checks++; if (ir_b !== 1'b1) begin errors++; $display("FAIL ns_ir_pop got %b exp 1", ir_b); end
        tick();
        checks++; if ({ov_b, alu_o_b} !== {1'b1, 16'h00BB}) begin errors++; $display("FAIL ns_pop_push got %h exp 100bb", {ov_b, alu_o_b}); end
        iv_b = 0;
        tick();
        checks++; if (ov_b !== 1'b0) begin errors++; $display("FAIL ns_drain got %b exp 0", ov_b); end
        checks++; if (st_b !== 2'd3) begin errors++; $display("FAIL ns_stall_keep got %0d exp 3", st_b); end
    endtask

    task automatic test_reset_midstall();
        or_a = 0; iv_a = 1; alu_a = 16'h5555;
        tick();
        tick();
        iv_a = 0; rst = 1;
        tick();
        rst = 0; or_a = 1;
        checks++; if ({ov_a, ir_a, st_a} !== {1'b0, 1'b1, 16'd0}) begin errors++; $display("FAIL rst_midstall got %h exp %h", {ov_a, ir_a, st_a}, {1'b0, 1'b1, 16'd0}); end
        tick();
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL rst_no_skid got %b exp 0", ov_a); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble_gating();
        test_noskid_saturate();
        test_reset_midstall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
